// File: rtl/countdown_timer_mmss.sv
// Loadable mm:ss BCD countdown timer driven by a 1 Hz clk_sec tick.
// Counts down while running, raises a bounded alarm at 00:00, then returns to idle.
module countdown_timer_mmss #(
    parameter int ALARM_SEC = 5
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       clk_sec,
    input  logic       load,
    input  logic [3:0] set_sec1,
    input  logic [3:0] set_sec10,
    input  logic [3:0] set_min1,
    input  logic [3:0] set_min10,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] sec1,
    output logic [3:0] sec10,
    output logic [3:0] min1,
    output logic [3:0] min10,
    output logic       running,
    output logic       alarm,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    localparam logic [3:0] ALARM_LAST = 4'(ALARM_SEC - 1);

    state_t     state, state_n;
    logic [3:0] sec1_n, sec10_n, min1_n, min10_n;
    logic [3:0] dec_s1, dec_s10, dec_m1, dec_m10;
    logic [3:0] alarm_cnt, alarm_cnt_n;
    logic       done_n;
    logic       count_zero, dec_zero;

    assign count_zero = ({min10, min1, sec10, sec1} == 16'h0000);

    // One-second BCD borrow chain; never evaluated from 00:00 because RUN exits there.
    always_comb begin
        dec_s1  = sec1;
        dec_s10 = sec10;
        dec_m1  = min1;
        dec_m10 = min10;
        if (sec1 != 4'd0) begin
            dec_s1 = sec1 - 4'd1;
        end else begin
            dec_s1 = 4'd9;
            if (sec10 != 4'd0) begin
                dec_s10 = sec10 - 4'd1;
            end else begin
                dec_s10 = 4'd5;
                if (min1 != 4'd0) begin
                    dec_m1 = min1 - 4'd1;
                end else begin
                    dec_m1  = 4'd9;
                    dec_m10 = min10 - 4'd1;
                end
            end
        end
    end

    assign dec_zero = ({dec_m10, dec_m1, dec_s10, dec_s1} == 16'h0000);

    always_comb begin
        state_n     = state;
        sec1_n      = sec1;
        sec10_n     = sec10;
        min1_n      = min1;
        min10_n     = min10;
        alarm_cnt_n = alarm_cnt;
        done_n      = 1'b0;
        case (state)
            S_IDLE, S_PAUSE: begin
                // Load beats start; stop alone has nothing to pause here.
                if (load) begin
                    sec1_n  = (set_sec1  > 4'd9) ? 4'd9 : set_sec1;
                    sec10_n = (set_sec10 > 4'd5) ? 4'd5 : set_sec10;
                    min1_n  = (set_min1  > 4'd9) ? 4'd9 : set_min1;
                    min10_n = (set_min10 > 4'd5) ? 4'd5 : set_min10;
                end else if (start && !stop && !count_zero) begin
                    state_n = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_n = S_PAUSE;
                end else if (clk_sec) begin
                    sec1_n  = dec_s1;
                    sec10_n = dec_s10;
                    min1_n  = dec_m1;
                    min10_n = dec_m10;
                    if (dec_zero) begin
                        state_n     = S_ALARM;
                        alarm_cnt_n = 4'd0;
                        done_n      = 1'b1;
                    end
                end
            end
            S_ALARM: begin
                if (stop) begin
                    state_n = S_IDLE;
                end else if (clk_sec) begin
                    if (alarm_cnt == ALARM_LAST) begin
                        state_n = S_IDLE;
                    end else begin
                        alarm_cnt_n = alarm_cnt + 4'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state     <= S_IDLE;
            sec1      <= 4'd0;
            sec10     <= 4'd0;
            min1      <= 4'd0;
            min10     <= 4'd0;
            alarm_cnt <= 4'd0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            sec1      <= sec1_n;
            sec10     <= sec10_n;
            min1      <= min1_n;
            min10     <= min10_n;
            alarm_cnt <= alarm_cnt_n;
            done      <= done_n;
        end
    end

    assign running = (state == S_RUN);
    assign alarm   = (state == S_ALARM);

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// Self-checking bench for countdown_timer_mmss: a seconds-based reference model
// pushes expected outputs into a scoreboard queue that is drained after each clock.
module tb_countdown_timer_mmss;

    localparam int ALARM_SEC = 5;

    logic       clk = 1'b0;
    logic       reset_p = 1'b0;
    logic       clk_sec = 1'b0;
    logic       load = 1'b0;
    logic [3:0] set_sec1 = 4'd0, set_sec10 = 4'd0, set_min1 = 4'd0, set_min10 = 4'd0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [3:0] sec1, sec10, min1, min10;
    logic       running, alarm, done;

    int checks = 0;
    int errors = 0;

    // Reference model state: remaining time in whole seconds, not BCD digits.
    int m_secs = 0;
    int m_state = 0;
    int m_ticks = 0;
    bit m_done = 1'b0;

    logic [18:0] sb_queue[$];

    countdown_timer_mmss #(.ALARM_SEC(ALARM_SEC)) dut (
        .clk(clk), .reset_p(reset_p), .clk_sec(clk_sec), .load(load),
        .set_sec1(set_sec1), .set_sec10(set_sec10), .set_min1(set_min1), .set_min10(set_min10),
        .start(start), .stop(stop),
        .sec1(sec1), .sec10(sec10), .min1(min1), .min10(min10),
        .running(running), .alarm(alarm), .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [18:0] modelVec();
        int mm, ss;
        mm = m_secs / 60;
        ss = m_secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                (m_state == 1), (m_state == 3), m_done};
    endfunction

    function automatic int clampDigit(input logic [3:0] d, input int maxv);
        return (int'(d) > maxv) ? maxv : int'(d);
    endfunction

    // Drives one clock of inputs, advances the model, and checks the DUT after the edge.
    task automatic applyStimulus(input string tag, input bit rst, input bit ld, input bit st,
                                 input bit sp, input bit tick, input logic [15:0] set_val);
        @(negedge clk);
        reset_p = rst; load = ld; start = st; stop = sp; clk_sec = tick;
        {set_min10, set_min1, set_sec10, set_sec1} = set_val;
        m_done = 1'b0;
        if (rst) begin
            m_secs = 0; m_state = 0; m_ticks = 0;
        end else begin
            case (m_state)
                0, 2: begin
                    if (ld)
                        m_secs = (clampDigit(set_val[15:12], 5) * 10 + clampDigit(set_val[11:8], 9)) * 60
                               + clampDigit(set_val[7:4], 5) * 10 + clampDigit(set_val[3:0], 9);
                    else if (st && !sp && m_secs != 0)
                        m_state = 1;
                end
                1: begin
                    if (sp) m_state = 2;
                    else if (tick) begin
                        m_secs = m_secs - 1;
                        if (m_secs == 0) begin
                            m_state = 3; m_ticks = 0; m_done = 1'b1;
                        end
                    end
                end
                default: begin
                    if (sp) m_state = 0;
                    else if (tick) begin
                        m_ticks = m_ticks + 1;
                        if (m_ticks == ALARM_SEC) m_state = 0;
                    end
                end
            endcase
        end
        sb_queue.push_back(modelVec());
        @(posedge clk);
        #1;
        checkOutput(tag, {13'd0, min10, min1, sec10, sec1, running, alarm, done}, {13'd0, sb_queue.pop_front()});
    endtask

    task automatic idleCycles(input string tag, input int n, input bit tick);
        for (int i = 0; i < n; i++) applyStimulus(tag, 0, 0, 0, 0, tick, 16'h0000);
    endtask

    initial begin
        applyStimulus("reset", 1, 0, 0, 0, 0, 16'h0000);
        checkOutput("reset_digits", {16'd0, min10, min1, sec10, sec1}, 32'h0);

        // Reset in the middle of a run
        applyStimulus("load_0130", 0, 1, 0, 0, 0, 16'h0130);
        applyStimulus("start", 0, 0, 1, 0, 0, 16'h0000);
        idleCycles("run_tick", 3, 1);
        checkOutput("run_0127", {16'd0, min10, min1, sec10, sec1}, 32'h0127);
        applyStimulus("reset_run", 1, 0, 0, 0, 1, 16'h0000);
        checkOutput("reset_run_flags", {29'd0, running, alarm, done}, 32'h0);

        // Borrow chain
        applyStimulus("load_1000", 0, 1, 0, 0, 0, 16'h1000);
        applyStimulus("start", 0, 0, 1, 0, 0, 16'h0000);
        applyStimulus("tick", 0, 0, 0, 0, 1, 16'h0000);
        checkOutput("borrow_0959", {16'd0, min10, min1, sec10, sec1}, 32'h0959);
        applyStimulus("tick", 0, 0, 0, 0, 1, 16'h0000);
        checkOutput("borrow_0958", {16'd0, min10, min1, sec10, sec1}, 32'h0958);
        applyStimulus("stop", 0, 0, 0, 1, 0, 16'h0000);
        applyStimulus("load_0010", 0, 1, 0, 0, 0, 16'h0010);
        applyStimulus("start", 0, 0, 1, 0, 0, 16'h0000);
        applyStimulus("tick", 0, 0, 0, 0, 1, 16'h0000);
        checkOutput("borrow_0009", {16'd0, min10, min1, sec10, sec1}, 32'h0009);

        // Expiry and alarm duration
        applyStimulus("stop", 0, 0, 0, 1, 0, 16'h0000);
        applyStimulus("load_0002", 0, 1, 0, 0, 0, 16'h0002);
        applyStimulus("start", 0, 0, 1, 0, 0, 16'h0000);
        idleCycles("expire_tick", 2, 1);
        checkOutput("done_pulse", {29'd0, running, alarm, done}, 32'b011);
        idleCycles("alarm_hold", 1, 0);
        checkOutput("done_cleared", {29'd0, running, alarm, done}, 32'b010);
        idleCycles("alarm_tick", 4, 1);
        checkOutput("alarm_4th_tick", {31'd0, alarm}, 32'd1);
        idleCycles("alarm_tick5", 1, 1);
        checkOutput("alarm_expired", {31'd0, alarm}, 32'd0);

        // Pause, resume and acknowledge
        applyStimulus("load_0005", 0, 1, 0, 0, 0, 16'h0005);
        applyStimulus("start", 0, 0, 1, 0, 0, 16'h0000);
        idleCycles("run_tick", 2, 1);
        applyStimulus("pause", 0, 0, 0, 1, 0, 16'h0000);
        idleCycles("pause_tick", 3, 1);
        checkOutput("paused_0003", {16'd0, min10, min1, sec10, sec1}, 32'h0003);
        applyStimulus("resume", 0, 0, 1, 0, 0, 16'h0000);
        idleCycles("run_tick", 3, 1);
        checkOutput("alarm_reached", {31'd0, alarm}, 32'd1);
        applyStimulus("ack", 0, 0, 0, 1, 0, 16'h0000);
        checkOutput("ack_flags", {29'd0, running, alarm, done}, 32'h0);

        // Sanitise and ignored inputs
        applyStimulus("load_clamp", 0, 1, 0, 0, 0, 16'h947C);
        checkOutput("clamp_5459", {16'd0, min10, min1, sec10, sec1}, 32'h5459);
        applyStimulus("load_zero", 0, 1, 0, 0, 0, 16'h0000);
        applyStimulus("start_zero", 0, 0, 1, 0, 0, 16'h0000);
        checkOutput("start_zero_idle", {31'd0, running}, 32'd0);
        applyStimulus("load_0003", 0, 1, 0, 0, 0, 16'h0003);
        applyStimulus("start", 0, 0, 1, 0, 0, 16'h0000);
        applyStimulus("load_in_run", 0, 1, 0, 0, 0, 16'h0040);
        checkOutput("run_load_ignored", {16'd0, min10, min1, sec10, sec1}, 32'h0003);

        // Collisions
        applyStimulus("start_stop", 0, 0, 1, 1, 0, 16'h0000);
        checkOutput("start_stop_pause", {31'd0, running}, 32'd0);
        applyStimulus("resume", 0, 0, 1, 0, 0, 16'h0000);
        idleCycles("run_tick", 2, 1);
        applyStimulus("stop_tick", 0, 0, 0, 1, 1, 16'h0000);
        checkOutput("stop_tick_0001", {12'd0, min10, min1, sec10, sec1, running, alarm, done}, {12'd0, 16'h0001, 3'b000});
        applyStimulus("reset", 1, 0, 0, 0, 0, 16'h0000);
        applyStimulus("load_start", 0, 1, 1, 0, 0, 16'h0230);
        checkOutput("load_start_val", {12'd0, min10, min1, sec10, sec1, running, alarm, done}, {12'd0, 16'h0230, 3'b000});
        idleCycles("idle_tick", 2, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
